// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scanner
package keypad_pkg;

    localparam int KEY_CODE_W = 4;
    localparam int ROWS       = 4;
    localparam int COLS       = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        RELEASE  = 2'd2
    } scan_state_t;

    // Column drive patterns indexed by col_idx; exactly one column pulled low.
    localparam logic [COLS-1:0] COL_DRIVE [COLS] = '{
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

    // Index of the lowest active-low row; only meaningful when some row is low.
    function automatic logic [1:0] lowest_low_row(input logic [ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - key code valid/ack handshake towards the Nios PIO
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [KEY_CODE_W-1:0] key_code_out;
    logic                  key_valid_out;
    logic                  key_ack_in;
    logic                  key_overrun_out;

    modport master (
        output key_code_out,
        output key_valid_out,
        output key_overrun_out,
        input  key_ack_in
    );

    modport slave (
        input  key_code_out,
        input  key_valid_out,
        input  key_overrun_out,
        output key_ack_in
    );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous inputs
module sync_2ff #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_12m_in,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk_12m_in or posedge reset) begin
        if (reset) begin
            meta  <= RESET_VAL;
            q_out <= RESET_VAL;
        end else begin
            meta  <= d_in;
            q_out <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic               clk_12m_in,
    input  logic               reset,
    input  logic               scan_tick_in,
    input  logic [ROWS-1:0]    row_in,
    output logic [COLS-1:0]    col_out,
    keypad_scanner_if.master   kif
);

    localparam logic [3:0] DB_TICKS = 4'(DEBOUNCE_TICKS);

    logic [ROWS-1:0] rows_s;

    // Rows idle high (pulled up), so the synchronizer resets to "nothing pressed".
    sync_2ff #(
        .WIDTH     (ROWS),
        .RESET_VAL ({ROWS{1'b1}})
    ) u_row_sync (
        .clk_12m_in (clk_12m_in),
        .reset      (reset),
        .d_in       (row_in),
        .q_out      (rows_s)
    );

    scan_state_t           state, state_n;
    logic [1:0]            col_idx, col_idx_n;
    logic [1:0]            cand_row, cand_row_n;
    logic [1:0]            cand_col, cand_col_n;
    logic [3:0]            count, count_n;
    logic [KEY_CODE_W-1:0] key_code, key_code_n;
    logic                  key_valid, key_valid_n;
    logic                  key_overrun, key_overrun_n;
    logic                  publish;
    logic                  pressed;
    logic [1:0]            low_row;

    assign pressed = ~&rows_s;
    assign low_row = lowest_low_row(rows_s);

    assign col_out             = COL_DRIVE[col_idx];
    assign kif.key_code_out    = key_code;
    assign kif.key_valid_out   = key_valid;
    assign kif.key_overrun_out = key_overrun;

    // State and handshake registers.
    always_ff @(posedge clk_12m_in or posedge reset) begin
        if (reset) begin
            state       <= SCAN;
            col_idx     <= 2'd0;
            cand_row    <= 2'd0;
            cand_col    <= 2'd0;
            count       <= 4'd0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_overrun <= 1'b0;
        end else begin
            state       <= state_n;
            col_idx     <= col_idx_n;
            cand_row    <= cand_row_n;
            cand_col    <= cand_col_n;
            count       <= count_n;
            key_code    <= key_code_n;
            key_valid   <= key_valid_n;
            key_overrun <= key_overrun_n;
        end
    end

    // Scan/debounce sequencing on ticks, then the publish/ack handshake.
    always_comb begin
        state_n       = state;
        col_idx_n     = col_idx;
        cand_row_n    = cand_row;
        cand_col_n    = cand_col;
        count_n       = count;
        key_code_n    = key_code;
        key_valid_n   = key_valid;
        key_overrun_n = key_overrun;
        publish       = 1'b0;

        if (scan_tick_in) begin
            unique case (state)
                SCAN: begin
                    if (pressed) begin
                        cand_row_n = low_row;
                        cand_col_n = col_idx;
                        if (DB_TICKS == 4'd1) begin
                            publish = 1'b1;
                            count_n = 4'd0;
                            state_n = RELEASE;
                        end else begin
                            count_n = 4'd1;
                            state_n = DEBOUNCE;
                        end
                    end else begin
                        col_idx_n = col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!rows_s[cand_row]) begin
                        if (count + 4'd1 == DB_TICKS) begin
                            publish = 1'b1;
                            count_n = 4'd0;
                            state_n = RELEASE;
                        end else begin
                            count_n = count + 4'd1;
                        end
                    end else begin
                        count_n = 4'd0;
                        state_n = SCAN;
                    end
                end
                RELEASE: begin
                    if (!pressed) begin
                        if (count + 4'd1 == DB_TICKS) begin
                            count_n   = 4'd0;
                            col_idx_n = col_idx + 2'd1;
                            state_n   = SCAN;
                        end else begin
                            count_n = count + 4'd1;
                        end
                    end else begin
                        count_n = 4'd0;
                    end
                end
                default: begin
                    count_n = 4'd0;
                    state_n = SCAN;
                end
            endcase
        end

        // A publish beats a simultaneous ack; overrun only when the old key was unconsumed.
        if (publish) begin
            key_code_n    = {cand_row_n, cand_col_n};
            key_valid_n   = 1'b1;
            key_overrun_n = kif.key_ack_in ? 1'b0 : (key_overrun | key_valid);
        end else if (kif.key_ack_in && key_valid) begin
            key_valid_n   = 1'b0;
            key_overrun_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic        scan_tick;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] keys;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0] code;
        logic       ovr;
    } exp_t;

    exp_t       sb_q[$];
    logic       prev_v;
    logic [3:0] prev_c;

    keypad_scanner_if kif ();

    keypad_scanner #(.DEBOUNCE_TICKS(3)) dut (
        .clk_12m_in   (clk),
        .reset        (rst),
        .scan_tick_in (scan_tick),
        .row_in       (row_in),
        .col_out      (col_out),
        .kif          (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] col_pat(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    task automatic tick();
        repeat (2) @(posedge clk);
        #1 scan_tick = 1'b1;
        @(posedge clk);
        #1 scan_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ack();
        @(posedge clk);
        #1 kif.key_ack_in = 1'b1;
        @(posedge clk);
        #1 kif.key_ack_in = 1'b0;
    endtask

    task automatic goto_col(input int c);
        for (int i = 0; i < 8 && col_out !== col_pat(c); i++) tick();
        chk("goto_col", 32'(col_out), 32'(col_pat(c)));
    endtask

    task automatic press(input int r, input int c);
        keys[r*4+c] = 1'b1;
    endtask

    // Publish monitor: a rising valid or a changed code while valid is a new key.
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
            prev_c = 4'h0;
        end else begin
            if (kif.key_valid_out && (!prev_v || kif.key_code_out != prev_c)) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_publish", 32'(kif.key_valid_out), 32'(0));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_code", 32'(kif.key_code_out), 32'(e.code));
                    chk("sb_overrun", 32'(kif.key_overrun_out), 32'(e.ovr));
                end
            end
            prev_v = kif.key_valid_out;
            prev_c = kif.key_code_out;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        scan_tick      = 1'b0;
        keys           = '0;
        kif.key_ack_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset values, free-running scan
        chk("rst_col", 32'(col_out), 32'(4'b1110));
        chk("rst_valid", 32'(kif.key_valid_out), 32'(0));
        chk("rst_code", 32'(kif.key_code_out), 32'(0));
        chk("rst_ovr", 32'(kif.key_overrun_out), 32'(0));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("scan_col", 32'(col_out), 32'(col_pat((i + 1) % 4)));
        end
        chk("scan_valid", 32'(kif.key_valid_out), 32'(0));

        // 2: key A held on column 2, ack, no repeat while held
        goto_col(2);
        press(2, 2);
        sb_q.push_back('{code: 4'hA, ovr: 1'b0});
        ticks(3);
        chk("keyA_valid", 32'(kif.key_valid_out), 32'(1));
        chk("keyA_code", 32'(kif.key_code_out), 32'(4'hA));
        ack();
        chk("keyA_ack_valid", 32'(kif.key_valid_out), 32'(0));
        ticks(6);
        chk("keyA_hold_valid", 32'(kif.key_valid_out), 32'(0));
        keys = '0;
        ticks(3);
        chk("keyA_release_col", 32'(col_out), 32'(4'b0111));

        // 3: bounce on column 0 is rejected without advancing the column
        goto_col(0);
        press(1, 0);
        ticks(2);
        keys = '0;
        tick();
        chk("bounce_col_held", 32'(col_out), 32'(4'b1110));
        chk("bounce_valid", 32'(kif.key_valid_out), 32'(0));
        tick();
        chk("bounce_col_next", 32'(col_out), 32'(4'b1101));

        // 4: overrun when a second key lands before ack
        goto_col(1);
        press(1, 1);
        sb_q.push_back('{code: 4'h5, ovr: 1'b0});
        ticks(3);
        keys = '0;
        ticks(3);
        press(0, 3);
        sb_q.push_back('{code: 4'h3, ovr: 1'b1});
        ticks(4);
        chk("ovr_code", 32'(kif.key_code_out), 32'(4'h3));
        chk("ovr_flag", 32'(kif.key_overrun_out), 32'(1));
        ack();
        chk("ovr_ack_valid", 32'(kif.key_valid_out), 32'(0));
        chk("ovr_ack_flag", 32'(kif.key_overrun_out), 32'(0));
        keys = '0;
        ticks(3);

        // 5: two rows on column 1, lowest row index wins
        goto_col(1);
        press(1, 1);
        press(3, 1);
        sb_q.push_back('{code: 4'h5, ovr: 1'b0});
        ticks(3);
        chk("multi_code", 32'(kif.key_code_out), 32'(4'h5));
        ack();
        keys = '0;
        ticks(3);

        // 6: reset while debouncing with a key still pending
        goto_col(2);
        press(0, 2);
        sb_q.push_back('{code: 4'h2, ovr: 1'b0});
        ticks(3);
        keys = '0;
        ticks(3);
        press(2, 3);
        ticks(2);
        chk("pre_rst_valid", 32'(kif.key_valid_out), 32'(1));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_col", 32'(col_out), 32'(4'b1110));
        chk("mid_rst_valid", 32'(kif.key_valid_out), 32'(0));
        chk("mid_rst_code", 32'(kif.key_code_out), 32'(0));
        chk("mid_rst_ovr", 32'(kif.key_overrun_out), 32'(0));
        keys = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_col", 32'(col_out), 32'(4'b1101));
        chk("post_rst_valid", 32'(kif.key_valid_out), 32'(0));

        repeat (4) @(posedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
